// File: rtl/eth_arb_pkg.sv
// Shared types and helpers for the packet-atomic TX arbiter.
// The default AXI-Stream widths and the arbiter FSM encoding live here.
package eth_arb_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned KEEP_W  = DATA_W / 8;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/eth_arb_pick.sv
// Combinational requester pick: first asserted request at or after ptr_i, wrapping.
// With ptr_i tied to 0 this degenerates to fixed lowest-index priority.
module eth_arb_pick #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [NUM_REQ-1:0]   rot_req;
  logic [NUM_REQ-1:0]   rot_gnt;
  logic [2*NUM_REQ-1:0] gnt_dbl;

  // Rotate so the pointer slot is bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_req = NUM_REQ'({req_i, req_i} >> ptr_i);
    rot_gnt = rot_req & (~rot_req + NUM_REQ'(1));
    gnt_dbl = {rot_gnt, rot_gnt} << ptr_i;
    grant_o = gnt_dbl[2*NUM_REQ-1 -: NUM_REQ];
  end

endmodule

// File: rtl/eth_tx_pkt_arbiter.sv
// Packet-atomic arbiter sharing one TX AXI-Stream between NUM_REQ requesters.
// Define ETH_ARB_RR_EN for round-robin; otherwise lowest index wins.
module eth_tx_pkt_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_BEATS = 1024,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned KEEP_W   = DATA_W / 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         s_axis_tvalid,
  input  logic [NUM_REQ*DATA_W-1:0]  s_axis_tdata,
  input  logic [NUM_REQ*KEEP_W-1:0]  s_axis_tkeep,
  input  logic [NUM_REQ-1:0]         s_axis_tlast,
  input  logic [NUM_REQ-1:0]         s_axis_tuser,
  output logic [NUM_REQ-1:0]         s_axis_tready,
  output logic                       m_axis_tvalid,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [KEEP_W-1:0]          m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  input  logic                       m_axis_tready,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [NUM_REQ*CNT_W-1:0]   o_pkt_cnt,
  output logic [NUM_REQ-1:0]         o_oversize,
  input  logic                       i_stat_clr
);

  import eth_arb_pkg::*;

  localparam int unsigned BEAT_W = $clog2(MAX_BEATS) + 1;

  arb_state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]         grant_q, grant_d;
  logic [BEAT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ*CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [NUM_REQ-1:0]         oversize_q, oversize_d;

  logic                       busy;
  logic                       sel_valid, sel_last, sel_user;
  logic [DATA_W-1:0]          sel_data;
  logic [KEEP_W-1:0]          sel_keep;
  logic                       over_beat;
  logic                       hs, last_hs;
  logic [NUM_REQ-1:0]         pick_req, pick_gnt;
  logic [2:0]                 pick_ptr;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant_q[r]) begin
        sel_valid = s_axis_tvalid[r];
        sel_last  = s_axis_tlast[r];
        sel_user  = s_axis_tuser[r];
        sel_data  = s_axis_tdata[r*DATA_W +: DATA_W];
        sel_keep  = s_axis_tkeep[r*KEEP_W +: KEEP_W];
      end
    end

    busy          = (state_q == ARB_BUSY);
    over_beat     = (beat_cnt_q >= BEAT_W'(MAX_BEATS));
    m_axis_tvalid = busy & sel_valid;
    m_axis_tdata  = busy ? sel_data : '0;
    m_axis_tkeep  = busy ? sel_keep : '0;
    m_axis_tlast  = busy & sel_last;
    m_axis_tuser  = busy & (sel_user | over_beat);
    s_axis_tready = busy ? (grant_q & {NUM_REQ{m_axis_tready}}) : '0;

    hs      = m_axis_tvalid & m_axis_tready;
    last_hs = hs & sel_last;
    // The owner's valid on its tlast beat belongs to the packet just finished.
    pick_req = busy ? (s_axis_tvalid & ~grant_q) : s_axis_tvalid;
  end

  eth_arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (pick_req),
    .ptr_i   (pick_ptr),
    .grant_o (pick_gnt)
  );

`ifdef ETH_ARB_RR_EN
  logic [2:0] ptr_q, ptr_d, ptr_after, owner_idx;

  always_comb begin
    owner_idx = onehot_to_idx(MAX_REQ'(grant_q));
    ptr_after = (owner_idx == 3'(NUM_REQ - 1)) ? 3'd0 : owner_idx + 3'd1;
    ptr_d     = last_hs ? ptr_after : ptr_q;
    pick_ptr  = busy ? ptr_after : ptr_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  assign pick_ptr = 3'd0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    oversize_d = oversize_q;

    case (state_q)
      ARB_IDLE: begin
        if (|s_axis_tvalid) begin
          state_d = ARB_BUSY;
          grant_d = pick_gnt;
        end
      end
      ARB_BUSY: begin
        if (last_hs) begin
          beat_cnt_d = '0;
          if (|pick_req) begin
            grant_d = pick_gnt;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end else if (hs && !over_beat) begin
          // Saturate once oversize: every later beat stays flagged.
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase

    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant_q[r] && hs && over_beat) oversize_d[r] = 1'b1;
      if (grant_q[r] && last_hs) begin
        pkt_cnt_d[r*CNT_W +: CNT_W] = pkt_cnt_q[r*CNT_W +: CNT_W] + 1'b1;
      end
    end

    if (i_stat_clr) begin
      pkt_cnt_d  = '0;
      oversize_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      oversize_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      oversize_q <= oversize_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_pkt_cnt  = pkt_cnt_q;
  assign o_oversize = oversize_q;

endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// Randomized bench for eth_tx_pkt_arbiter against a packet-level reference model.
// Small MAX_BEATS and CNT_W so oversize flagging and counter wrap are exercised.
module tb_eth_tx_pkt_arbiter;

  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned KEEP_W    = DATA_W / 8;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned CNT_W     = 3;
  localparam int          NCYC      = 4000;
  localparam int          RST_CYC   = 2100;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        s_tvalid = '0;
  logic [NUM_REQ*DATA_W-1:0] s_tdata  = '0;
  logic [NUM_REQ*KEEP_W-1:0] s_tkeep  = '0;
  logic [NUM_REQ-1:0]        s_tlast  = '0;
  logic [NUM_REQ-1:0]        s_tuser  = '0;
  logic [NUM_REQ-1:0]        s_tready;
  logic                      m_tvalid, m_tlast, m_tuser;
  logic [DATA_W-1:0]         m_tdata;
  logic [KEEP_W-1:0]         m_tkeep;
  logic                      m_tready = 1'b0;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ*CNT_W-1:0]  pkt_cnt;
  logic [NUM_REQ-1:0]        oversize;
  logic                      stat_clr = 1'b0;

  always #5 clk = ~clk;

  eth_tx_pkt_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS),
    .CNT_W     (CNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tready (m_tready),
    .o_grant       (grant),
    .o_pkt_cnt     (pkt_cnt),
    .o_oversize    (oversize),
    .i_stat_clr    (stat_clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Requester sources: beats left in the current packet and the beat on offer.
  int          rem   [NUM_REQ];
  logic [63:0] bdata [NUM_REQ];
  logic [7:0]  bkeep [NUM_REQ];
  bit          buser [NUM_REQ];
  bit          tv    [NUM_REQ];
  bit          rdy_tgl;

  // Reference model: who owns the link, beats so far, statistics.
  int owner;
  int beats;
  int ptr;
  int cnt [NUM_REQ];
  bit ovs [NUM_REQ];

  task automatic new_beat(input int r);
    bdata[r] = {$urandom, $urandom};
    bkeep[r] = (rem[r] == 1) ? 8'($urandom) : 8'hff;
    buser[r] = ($urandom % 8 == 0);
  endtask

  function automatic int choose(input bit req [NUM_REQ], input int p);
`ifdef ETH_ARB_RR_EN
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1;
    beats = 0;
    ptr   = 0;
    for (int r = 0; r < NUM_REQ; r++) begin
      cnt[r] = 0;
      ovs[r] = 1'b0;
      rem[r] = 0;
      tv[r]  = 1'b0;
    end
  endtask

  // mode 0: random, 1: ready toggling, 2: all busy with 1-beat packets, 3: quiet
  task automatic drive(input int mode, input bit do_rst);
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!do_rst && mode != 3 && rem[r] == 0 && (mode == 2 || $urandom % 3 == 0)) begin
        rem[r] = (mode == 2) ? 1 : int'($urandom_range(1, 7));
        new_beat(r);
      end
      tv[r] = !do_rst && rem[r] > 0 && (mode == 2 || $urandom % 5 != 0);
    end
    rdy_tgl = ~rdy_tgl;
    rst      = do_rst;
    m_tready = (mode == 1) ? rdy_tgl : (mode == 2) ? 1'b1 : ($urandom % 4 != 0);
    stat_clr = !do_rst && mode != 3 && ($urandom % 50 == 0);
    for (int r = 0; r < NUM_REQ; r++) begin
      s_tvalid[r]                   = tv[r];
      s_tlast[r]                    = (rem[r] == 1);
      s_tuser[r]                    = buser[r];
      s_tdata[r*DATA_W +: DATA_W]   = bdata[r];
      s_tkeep[r*KEEP_W +: KEEP_W]   = bkeep[r];
    end
  endtask

  task automatic check_outputs();
    logic [63:0] e_grant, e_cnt, e_ovs, e_rdy, e_data;
    logic [7:0]  e_keep;
    bit          e_valid, e_last, e_user;
    e_grant = '0; e_rdy = '0; e_data = '0; e_keep = '0;
    e_valid = 1'b0; e_last = 1'b0; e_user = 1'b0;
    e_cnt = '0; e_ovs = '0;
    if (owner >= 0) begin
      e_grant = 64'(1) << owner;
      e_valid = tv[owner];
      e_data  = bdata[owner];
      e_keep  = bkeep[owner];
      e_last  = (rem[owner] == 1);
      e_user  = buser[owner] || (beats >= MAX_BEATS);
      e_rdy   = m_tready ? (64'(1) << owner) : 64'(0);
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      e_cnt = e_cnt | (64'(cnt[r]) << (r * CNT_W));
      e_ovs = e_ovs | (64'(ovs[r]) << r);
    end
    check_eq("grant",    64'(grant),    e_grant);
    check_eq("tvalid",   64'(m_tvalid), 64'(e_valid));
    check_eq("tdata",    64'(m_tdata),  e_data);
    check_eq("tkeep",    64'(m_tkeep),  64'(e_keep));
    check_eq("tlast",    64'(m_tlast),  64'(e_last));
    check_eq("tuser",    64'(m_tuser),  64'(e_user));
    check_eq("s_tready", 64'(s_tready), e_rdy);
    check_eq("pkt_cnt",  64'(pkt_cnt),  e_cnt);
    check_eq("oversize", 64'(oversize), e_ovs);
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_step();
    bit hs, any;
    bit pend [NUM_REQ];
    int nxt;
    if (rst) begin
      model_reset();
      return;
    end
    nxt = owner;
    hs  = (owner >= 0) && tv[owner] && m_tready;
    if (hs) begin
      if (beats >= MAX_BEATS) ovs[owner] = 1'b1;
      if (rem[owner] == 1) begin
        cnt[owner] = (cnt[owner] + 1) % (1 << CNT_W);
        beats = 0;
        ptr   = (owner + 1) % NUM_REQ;
        for (int r = 0; r < NUM_REQ; r++) pend[r] = tv[r] && (r != owner);
        nxt = choose(pend, ptr);
      end else begin
        beats++;
      end
      rem[owner]--;
      if (rem[owner] > 0) new_beat(owner);
    end else if (owner < 0) begin
      any = 1'b0;
      for (int r = 0; r < NUM_REQ; r++) any |= tv[r];
      if (any) nxt = choose(tv, ptr);
    end
    owner = nxt;
    if (stat_clr) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        cnt[r] = 0;
        ovs[r] = 1'b0;
      end
    end
  endtask

  initial begin
    rdy_tgl = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      bdata[r] = '0;
      bkeep[r] = '0;
      buser[r] = 1'b0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: everything must stay quiet.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 drive(3, 1'b0);
      @(negedge clk);
      check_outputs();
      model_step();
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1 drive((c / 400) % 3, c == RST_CYC);
      @(negedge clk);
      if (!rst) check_outputs();
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
